// File: rtl/ram_fifo_ctrl_if.sv
// Streaming FIFO handshakes plus the dual-port RAM control bundle.
// The controller binds the slave modport; the producer/consumer/RAM side binds master.
interface ram_fifo_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [AWIDTH+1:0] count;
  logic [AWIDTH-1:0] ram_addr0;
  logic [DWIDTH-1:0] ram_d0;
  logic              ram_we0;
  logic [AWIDTH-1:0] ram_addr1;
  logic [DWIDTH-1:0] ram_d1;
  logic              ram_we1;
  logic [DWIDTH-1:0] ram_q1;

  modport slave (
    input  in_data, in_valid, out_ready, ram_q1,
    output in_ready, out_data, out_valid, count,
    output ram_addr0, ram_d0, ram_we0,
    output ram_addr1, ram_d1, ram_we1
  );

  modport master (
    output in_data, in_valid, out_ready, ram_q1,
    input  in_ready, out_data, out_valid, count,
    input  ram_addr0, ram_d0, ram_we0,
    input  ram_addr1, ram_d1, ram_we1
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a dual-port sync-read RAM; a 2-entry output
// buffer hides the read latency so the stream runs at one word per cycle.
module ram_fifo_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  bus
);
  localparam int CW = AWIDTH + 2;
  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_count_q, ram_count_d;
  logic              rd_pending_q, rd_pending_d;
  logic [DWIDTH-1:0] buf0_q, buf0_d;
  logic [DWIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]        buf_count_q, buf_count_d;

  logic       push, pop, rd_issue;
  logic [2:0] occ;
  logic [1:0] slot;

  always_comb begin
    bus.in_ready = (ram_count_q < FULL) & rst;
    push         = bus.in_valid & bus.in_ready;
    bus.out_valid = (buf_count_q != 2'd0);
    bus.out_data  = buf0_q;
    pop          = bus.out_valid & bus.out_ready;
    // slots committed after this edge: buffered + in flight - leaving
    occ          = {1'b0, buf_count_q} + {2'b0, rd_pending_q};
    rd_issue     = (ram_count_q != '0) &
                   (occ < (3'd2 + {2'b0, pop}));

    bus.ram_we0   = push;
    bus.ram_addr0 = wr_ptr_q;
    bus.ram_d0    = bus.in_data;
    bus.ram_addr1 = rd_ptr_q;
    bus.ram_d1    = '0;
    bus.ram_we1   = 1'b0;
    bus.count     = CW'(ram_count_q) + CW'(rd_pending_q)
                  + CW'(buf_count_q);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AWIDTH'(push);
    rd_ptr_d     = rd_ptr_q + AWIDTH'(rd_issue);
    ram_count_d  = ram_count_q + (AWIDTH+1)'(push)
                 - (AWIDTH+1)'(rd_issue);
    rd_pending_d = rd_issue;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    if (pop && buf_count_q == 2'd2) buf0_d = buf1_q;
    // capture lands in the first free slot after any pop shift
    slot = buf_count_q - 2'(pop);
    if (rd_pending_q) begin
      if (slot == 2'd0) buf0_d = bus.ram_q1;
      else              buf1_d = bus.ram_q1;
    end
    buf_count_d = buf_count_q - 2'(pop) + 2'(rd_pending_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pending_q <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      buf_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pending_q <= rd_pending_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      buf_count_q  <= buf_count_d;
    end
  end

  a_buf_bound: assert property (
    @(posedge clk) disable iff (!rst) buf_count_q <= 2'd2);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl with an external RAM model and a
// word-level reference queue tracking when each word becomes visible.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q1_r = '0;
  always @(posedge clk) begin
    if (bus.ram_we0) mem[bus.ram_addr0] <= bus.ram_d0;
    if (bus.ram_we1) mem[bus.ram_addr1] <= bus.ram_d1;
    q1_r <= mem[bus.ram_addr1];
  end
  assign bus.ram_q1 = q1_r;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: every stored word in order, with the edge it was read out
  logic [DW-1:0] md[$];
  int            mi[$];
  int  ni = 0;
  int  edges = 0;
  int  wr_tot = 0;
  int  rd_tot = 0;
  int  pops = 0;
  int  max_cnt = 0;
  logic [DW-1:0] last_out = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      md.delete(); mi.delete();
      ni = 0; wr_tot = 0; rd_tot = 0; last_out = '0;
      prev_hold = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_we0", bus.ram_we0, 0);
    end else begin
      logic mv, ir, pop, push, iss;
      int inram;
      mv = (ni > 0) && (mi[0] + 1 <= edges);
      inram = md.size() - ni;
      ir = inram < DEPTH;
      chk("out_valid", bus.out_valid, mv);
      chk("out_data", bus.out_data, mv ? md[0] : last_out);
      chk("in_ready", bus.in_ready, ir);
      chk("count", bus.count, md.size());
      chk("addr0", bus.ram_addr0, wr_tot % DEPTH);
      chk("addr1", bus.ram_addr1, rd_tot % DEPTH);
      chk("we1", bus.ram_we1, 0);
      if (prev_hold) chk("hold_stable", bus.out_data, prev_data);
      pop  = mv & bus.out_ready;
      push = bus.in_valid & ir;
      iss  = (inram > 0) && (ni - int'(pop) < 2);
      chk("we0", bus.ram_we0, push);
      prev_hold = bus.out_valid & ~bus.out_ready;
      prev_data = bus.out_data;
      if (md.size() > max_cnt) max_cnt = md.size();
      if (pop) begin
        last_out = md[0];
        void'(md.pop_front()); void'(mi.pop_front());
        ni--; pops++;
      end
      if (iss) begin
        mi[ni] = edges + 1; ni++; rd_tot++;
      end
      if (push) begin
        md.push_back(bus.in_data); mi.push_back(-1); wr_tot++;
      end
      edges++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int k;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.count != 0 && k < budget) begin
      cyc(); k++;
    end
    chk("drain_done", bus.count, 0);
  endtask

  initial begin
    int idx, p0, k;
    logic acc;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12 rst = 1'b1;
    @(negedge clk);
    chk("init_in_ready", bus.in_ready, 1);
    chk("init_out_data", bus.out_data, 8'h00);

    // single word latency
    cyc();
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("lat_e2_valid", bus.out_valid, 0);
    cyc();
    chk("lat_e3_valid", bus.out_valid, 1);
    chk("lat_e3_data", bus.out_data, 8'hA5);
    cyc();
    chk("lat_pop_count", bus.count, 0);

    // fill to capacity with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    idx = 0;
    for (int c = 0; c < 301; c++) begin
      bus.in_data = DW'(idx);
      @(negedge clk);
      acc = bus.in_ready;
      cyc();
      if (acc) idx++;
    end
    chk("fill_accepted", idx, 258);
    chk("fill_count", bus.count, 258);
    chk("fill_in_ready", bus.in_ready, 0);
    chk("fill_head", bus.out_data, 8'h00);
    drain(400);

    // back-to-back streaming
    p0 = pops;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      bus.in_data = DW'($urandom);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("stream_pops", pops - p0, 1000);
    chk("stream_empty", bus.count, 0);

    // random handshakes on both sides
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = DW'($urandom);
      bus.out_ready = $urandom_range(0, 1);
      cyc();
    end
    drain(400);

    // async reset mid-cycle with data stored
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.in_data = DW'($urandom);
      cyc();
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_count", bus.count, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    cyc();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      cyc(); k++;
    end
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_data", bus.out_data, 8'h3C);
    bus.out_ready = 1'b1;
    cyc();
    chk("post_rst_count", bus.count, 0);

    // sparse pushes: occupancy never exceeds one word
    max_cnt = 0;
    for (int c = 0; c < 90; c++) begin
      bus.in_valid = (c % 3 == 0);
      bus.in_data = DW'($urandom);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("sparse_max_count", max_cnt, 1);
    chk("sparse_empty", bus.count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Controller that turns an external dual-ported synchronous-read RAM into a streaming FIFO with valid/ready on both sides.
- Port 0 of the RAM is the write side. Port 1 is the read side.
- The RAM's 1-cycle read latency is hidden behind a 2-entry output buffer, so the FIFO sustains one word per cycle in and out.
- Sits directly in front of the RAM, driving its address and write-enable inputs and consuming its q1 output.

Parameters:
- DWIDTH, 8, data word width; must match the RAM's DWIDTH.
- AWIDTH, 8, RAM address width.
- DEPTH, 256, RAM word count; must equal 2**AWIDTH.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- in_data  in  DWIDTH  push data.
- in_valid  in  1  push request.
- in_ready  out  1  space available in the RAM.
- out_data  out  DWIDTH  head-of-FIFO data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data.
- count  out  AWIDTH+2  total words held: RAM + in-flight read + output buffer.
- ram_addr0  out  AWIDTH  RAM port-0 address (write pointer).
- ram_d0  out  DWIDTH  RAM port-0 write data; equals in_data.
- ram_we0  out  1  RAM port-0 write enable.
- ram_addr1  out  AWIDTH  RAM port-1 address (read pointer).
- ram_d1  out  DWIDTH  tied to 0.
- ram_we1  out  1  tied to 0.
- ram_q1  in  DWIDTH  RAM port-1 registered read data.

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clk) clears all state:
  - wr_ptr=0, rd_ptr=0, ram_count=0, rd_pending=0.
  - Buffer entries emptied; out_valid=0, out_data=0, count=0.
  - in_ready=0 and ram_we0=0 while rst=0.
  - Reset mid-operation discards all stored words; RAM contents are not cleared and are not needed.
- Push:
  - in_ready = (ram_count < DEPTH) and rst=1.
  - push = in_valid & in_ready.
  - ram_we0 = push (combinational); ram_addr0 = wr_ptr; ram_d0 = in_data.
  - On push, wr_ptr increments modulo DEPTH (natural AWIDTH wrap).
- Read issue:
  - ram_addr1 = rd_ptr at all times.
  - rd_issue = (ram_count > 0) & (buf_count + rd_pending - pop < 2).
  - pop = out_valid & out_ready.
  - ram_count is registered, so a word written on edge k is readable no earlier than the cycle after edge k. There is no same-address read/write hazard.
  - On rd_issue: rd_ptr increments modulo DEPTH, and rd_pending is set for the next cycle; otherwise rd_pending is cleared.
- Capture:
  - When rd_pending=1, ram_q1 is valid in that cycle and is written into the output buffer on that cycle's edge.
  - The buffer is a 2-entry in-order queue; its head drives out_data.
  - out_valid = (buf_count > 0).
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Pop and capture in the same cycle are both applied.
  - buf_count never exceeds 2; overflow is an implementation bug (assertion).
- Counters:
  - ram_count += push, -= rd_issue.
  - count = ram_count + rd_pending + buf_count.
  - Simultaneous push and rd_issue leaves ram_count unchanged.
  - Maximum count = DEPTH+2.
- Latency:
  - A word pushed on edge k into an empty FIFO has out_valid=1 in the cycle after edge k+2.
  - Steady-state throughput is 1 word/cycle with in_valid=out_ready=1.
- Boundary conditions:
  - Full (ram_count=DEPTH): in_ready=0; a same-cycle pop does not raise in_ready until ram_count drops.
  - Empty: out_valid=0, rd_issue=0, and out_data holds its last value.
  - Pointer wrap is silent; ordering is preserved across the wrap.

Test Plan:
- After reset, push 0xA5 at edge 1 with out_ready=1 -> out_valid=1 and out_data=0xA5 in the cycle after edge 3; popped; count returns to 0.
- out_ready=0, in_valid=1 continuous with data 0..300 -> exactly 258 words accepted, in_ready=0 thereafter, count=258. Then out_ready=1 -> out_data sequence 0..257 in order; in_ready reasserts once ram_count<256.
- Stream 1000 words with in_valid=out_ready=1 -> after the initial 2-cycle latency, one word per cycle, no gaps, in order; pointers wrap 3 times.
- Random out_ready (50% duty) during streaming -> no loss or duplication; out_data stable whenever out_valid=1 and out_ready=0.
- Fill 100 words, assert rst=0 asynchronously mid-cycle -> out_valid, in_ready and count go to 0 immediately. After release, push 0x3C -> out_data=0x3C (no stale data).
- Push exactly 1 word per 3 cycles with out_ready=1 -> count toggles between 0 and at most 1, with no spurious rd_issue when ram_count=0.
